// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line in, byte plus status out.
// Slave modport is the receiver itself; master modport is whoever drives the line
// and consumes the received byte.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data_out, rx_done, parity_err, frame_err, busy
  );

  modport slave (
    input  rx,
    output data_out, rx_done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for an 11-bit frame: start, 8 data bits MSB first, even parity, stop.
// Latency: rx_done rises 1+CLKS_PER_BIT/2+10*CLKS_PER_BIT edges after the first synchronizer flop sees the start bit.
// No backpressure: each completed frame overwrites data_out and flags and pulses rx_done for one cycle.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          sync1_q, sync2_q;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          done_q, done_d;

  assign rx_s = sync2_q;

  // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM next-state: bit timing, mid-bit sampling and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          // The cycle that detects the falling edge already belongs to the start
          // bit, so counting starts at 1 to land the check CLKS_PER_BIT/2 cycles
          // after detection, in the middle of the bit.
          cnt_d   = CW'(1);
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line back high at mid start bit is a glitch: drop it silently.
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shreg_d   = {shreg_q[6:0], rx_s};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // The byte is delivered even when a flag is raised; the flags only
          // qualify this frame and are rewritten on the next one.
          data_d  = shreg_q;
          perr_d  = ^{shreg_q, par_q};
          ferr_d  = ~rx_s;
          done_d  = 1'b1;
          // Returning to IDLE at mid stop bit leaves half a bit of margin to
          // catch an immediately following start bit.
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame FSM state, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      data_q    <= 8'h00;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.rx_done    = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames, then back-to-back,
// glitch and mid-frame reset sequences. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_uart_rx;
  localparam int CPB = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; at a falling edge cyc equals the number of edges so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which rx_done is seen high.
  int         n_done;
  int         d_cyc [64];
  logic [7:0] d_dat [64];
  logic       d_pe  [64];
  logic       d_fe  [64];

  initial n_done = 0;
  always @(negedge clk) begin
    if (u_if.rx_done === 1'b1) begin
      if (n_done < 64) begin
        d_cyc[n_done] = cyc;
        d_dat[n_done] = u_if.data_out;
        d_pe[n_done]  = u_if.parity_err;
        d_fe[n_done]  = u_if.frame_err;
      end
      n_done = n_done + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slot(input logic v, input int n);
    u_if.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a falling edge. e0 is the rising edge at which
  // the first synchronizer flop captures the start bit. A low stop bit is held
  // low only across its sampling point so the line is high again before the
  // receiver looks for the next start bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, output int e0);
    e0 = cyc + 1;
    slot(1'b0, CPB);
    for (int b = 7; b >= 0; b--) slot(d[b], CPB);
    slot(p, CPB);
    if (stop) begin
      slot(1'b1, CPB);
    end else begin
      slot(1'b0, CPB / 2);
      slot(1'b1, CPB / 2);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int e0;
    int e1;
    int base;

    checks = 0;
    errors = 0;
    //           data   par   stop  exp_d  pe    fe
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'hD5, 1'b1, 1'b1, 8'hD5, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    u_if.rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset data_out",   u_if.data_out,   8'h00);
    chk("reset rx_done",    u_if.rx_done,    1'b0);
    chk("reset parity_err", u_if.parity_err, 1'b0);
    chk("reset frame_err",  u_if.frame_err,  1'b0);
    chk("reset busy",       u_if.busy,       1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single frames with an idle gap between them.
    for (int i = 0; i < 9; i++) begin
      base = n_done;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].stop, e0);
      repeat (2 * CPB) @(negedge clk);
      chk($sformatf("vec%0d pulses", i),     n_done - base,  1);
      chk($sformatf("vec%0d done edge", i),  d_cyc[base],    e0 + 85);
      chk($sformatf("vec%0d data", i),       d_dat[base],    vecs[i].exp_d);
      chk($sformatf("vec%0d parity_err", i), d_pe[base],     vecs[i].exp_pe);
      chk($sformatf("vec%0d frame_err", i),  d_fe[base],     vecs[i].exp_fe);
      chk($sformatf("vec%0d busy idle", i),  u_if.busy,      1'b0);
    end

    // Back-to-back frames with no idle gap.
    base = n_done;
    send_frame(8'h3C, 1'b0, 1'b1, e0);
    send_frame(8'hC3, 1'b0, 1'b1, e1);
    repeat (2 * CPB) @(negedge clk);
    chk("b2b pulses",   n_done - base, 2);
    chk("b2b spacing",  d_cyc[base + 1] - d_cyc[base], 88);
    chk("b2b data0",    d_dat[base],     8'h3C);
    chk("b2b data1",    d_dat[base + 1], 8'hC3);
    chk("b2b flags0",   {d_pe[base], d_fe[base]},         2'b00);
    chk("b2b flags1",   {d_pe[base + 1], d_fe[base + 1]}, 2'b00);

    // Two-cycle low glitch: START is entered, then abandoned at mid start bit.
    base = n_done;
    e0 = cyc + 1;
    slot(1'b0, 2);
    slot(1'b1, 1);
    chk("glitch busy high", u_if.busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("glitch busy low",  u_if.busy, 1'b0);
    repeat (100) @(negedge clk);
    chk("glitch pulses",    n_done - base, 0);
    chk("glitch data held", u_if.data_out, 8'hC3);

    // Reset in the middle of data bit d[4] of an 8'h5A frame.
    base = n_done;
    slot(1'b0, CPB);
    slot(1'b0, CPB);
    slot(1'b1, CPB);
    slot(1'b0, CPB);
    slot(1'b1, CPB / 2);
    chk("midframe busy", u_if.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort data_out",   u_if.data_out,   8'h00);
    chk("abort rx_done",    u_if.rx_done,    1'b0);
    chk("abort parity_err", u_if.parity_err, 1'b0);
    chk("abort frame_err",  u_if.frame_err,  1'b0);
    chk("abort busy",       u_if.busy,       1'b0);
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort pulses", n_done - base, 0);

    base = n_done;
    send_frame(8'h5A, 1'b0, 1'b1, e0);
    repeat (2 * CPB) @(negedge clk);
    chk("post-reset pulses",     n_done - base, 1);
    chk("post-reset done edge",  d_cyc[base],   e0 + 85);
    chk("post-reset data",       d_dat[base],   8'h5A);
    chk("post-reset flags",      {d_pe[base], d_fe[base]}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
